// File: rtl/updown_mod_counter.sv
// Up/down counter with programmable modulus and step, parallel load, wrap-or-saturate
// boundary handling, a registered terminal-count pulse and sticky overflow/underflow flags.
module updown_mod_counter #(
   parameter int unsigned WIDTH = 4,
   parameter int unsigned MAX   = 9,
   parameter int unsigned STEP  = 1,
   parameter bit          SAT   = 1'b0
) (
   input  logic             CLK,
   input  logic             Clear,
   input  logic             EN,
   input  logic             UD,
   input  logic             Load,
   input  logic [WIDTH-1:0] LoadVal,
   input  logic             ClrFlags,
   output logic [WIDTH-1:0] Count,
   output logic             TC,
   output logic             Ovf,
   output logic             Udf
);

   // One extra bit so Count+STEP and Count+MAX+1 never overflow.
   localparam logic [WIDTH:0]   MaxW  = (WIDTH+1)'(MAX);
   localparam logic [WIDTH:0]   StepW = (WIDTH+1)'(STEP);
   localparam logic [WIDTH:0]   ModW  = MaxW + 1'b1;
   localparam logic [WIDTH-1:0] MaxN  = WIDTH'(MAX);
   localparam logic [WIDTH-1:0] StepN = WIDTH'(STEP);

   logic [WIDTH-1:0] count_q, count_d;
   logic             tc_q, tc_d;
   logic             ovf_q, ovf_d;
   logic             udf_q, udf_d;
   logic             set_ovf, set_udf;
   logic [WIDTH:0]   up_sum;

   always_comb begin
      count_d = count_q;
      tc_d    = 1'b0;
      set_ovf = 1'b0;
      set_udf = 1'b0;
      up_sum  = {1'b0, count_q} + StepW;

      if (Load) begin
         count_d = (LoadVal > MaxN) ? MaxN : LoadVal;
      end else if (EN) begin
         if (UD) begin
            if (up_sum <= MaxW) begin
               count_d = up_sum[WIDTH-1:0];
            end else begin
               count_d = SAT ? MaxN : WIDTH'(up_sum - ModW);
               tc_d    = 1'b1;
               set_ovf = 1'b1;
            end
         end else begin
            if (count_q >= StepN) begin
               count_d = count_q - StepN;
            end else begin
               count_d = SAT ? '0 : WIDTH'(({1'b0, count_q} + ModW) - StepW);
               tc_d    = 1'b1;
               set_udf = 1'b1;
            end
         end
      end

      // A flag being set on this edge wins over ClrFlags.
      ovf_d = set_ovf | (ovf_q & ~ClrFlags);
      udf_d = set_udf | (udf_q & ~ClrFlags);
   end

   always_ff @(posedge CLK) begin
      if (!Clear) begin
         count_q <= '0;
         tc_q    <= 1'b0;
         ovf_q   <= 1'b0;
         udf_q   <= 1'b0;
      end else begin
         count_q <= count_d;
         tc_q    <= tc_d;
         ovf_q   <= ovf_d;
         udf_q   <= udf_d;
      end
   end

   assign Count = count_q;
   assign TC    = tc_q;
   assign Ovf   = ovf_q;
   assign Udf   = udf_q;

endmodule

// File: tb/tb_updown_mod_counter.sv
// Bench for updown_mod_counter: four parameterisations share one stimulus stream and are
// checked every cycle against an arithmetic reference model, plus hand-computed literals.
module tb_updown_mod_counter;

   localparam int N = 4;
   localparam int P_MAX  [N] = '{9, 9, 9, 7};
   localparam int P_STEP [N] = '{1, 1, 3, 2};
   localparam int P_SAT  [N] = '{0, 1, 0, 1};

   logic       clk;
   logic       Clear, EN, UD, Load, ClrFlags;
   logic [3:0] lv;

   logic [3:0] d_cnt [N];
   logic       d_tc  [N];
   logic       d_ovf [N];
   logic       d_udf [N];
   logic [2:0] c3;

   int n_tests = 0;
   int n_fail  = 0;

   int m_cnt [N];
   int m_tc  [N];
   int m_ovf [N];
   int m_udf [N];
   bit m_valid = 1'b0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   updown_mod_counter #(.WIDTH(4), .MAX(9), .STEP(1), .SAT(1'b0)) u0 (
      .CLK(clk), .Clear(Clear), .EN(EN), .UD(UD), .Load(Load), .LoadVal(lv),
      .ClrFlags(ClrFlags), .Count(d_cnt[0]), .TC(d_tc[0]), .Ovf(d_ovf[0]), .Udf(d_udf[0])
   );
   updown_mod_counter #(.WIDTH(4), .MAX(9), .STEP(1), .SAT(1'b1)) u1 (
      .CLK(clk), .Clear(Clear), .EN(EN), .UD(UD), .Load(Load), .LoadVal(lv),
      .ClrFlags(ClrFlags), .Count(d_cnt[1]), .TC(d_tc[1]), .Ovf(d_ovf[1]), .Udf(d_udf[1])
   );
   updown_mod_counter #(.WIDTH(4), .MAX(9), .STEP(3), .SAT(1'b0)) u2 (
      .CLK(clk), .Clear(Clear), .EN(EN), .UD(UD), .Load(Load), .LoadVal(lv),
      .ClrFlags(ClrFlags), .Count(d_cnt[2]), .TC(d_tc[2]), .Ovf(d_ovf[2]), .Udf(d_udf[2])
   );
   updown_mod_counter #(.WIDTH(3), .MAX(7), .STEP(2), .SAT(1'b1)) u3 (
      .CLK(clk), .Clear(Clear), .EN(EN), .UD(UD), .Load(Load), .LoadVal(lv[2:0]),
      .ClrFlags(ClrFlags), .Count(c3), .TC(d_tc[3]), .Ovf(d_ovf[3]), .Udf(d_udf[3])
   );
   assign d_cnt[3] = {1'b0, c3};

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain integer arithmetic on the counting rules.
   always @(posedge clk) begin
      for (int i = 0; i < N; i++) begin
         int v, n, so, su;
         v  = (i == 3) ? int'(lv[2:0]) : int'(lv);
         so = 0;
         su = 0;
         if (!Clear) begin
            m_cnt[i] = 0;
            m_ovf[i] = 0;
            m_udf[i] = 0;
         end else if (Load) begin
            m_cnt[i] = (v > P_MAX[i]) ? P_MAX[i] : v;
         end else if (EN) begin
            if (UD) begin
               n = m_cnt[i] + P_STEP[i];
               if (n > P_MAX[i]) begin
                  so = 1;
                  n  = P_SAT[i] ? P_MAX[i] : n - (P_MAX[i] + 1);
               end
            end else begin
               n = m_cnt[i] - P_STEP[i];
               if (n < 0) begin
                  su = 1;
                  n  = P_SAT[i] ? 0 : n + P_MAX[i] + 1;
               end
            end
            m_cnt[i] = n;
         end
         m_tc[i] = so | su;
         if (Clear) begin
            m_ovf[i] = (so != 0 || (m_ovf[i] != 0 && !ClrFlags)) ? 1 : 0;
            m_udf[i] = (su != 0 || (m_udf[i] != 0 && !ClrFlags)) ? 1 : 0;
         end
      end
      if (!Clear) m_valid = 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         for (int i = 0; i < N; i++) begin
            chk($sformatf("u%0d.Count", i), int'(d_cnt[i]), m_cnt[i]);
            chk($sformatf("u%0d.TC", i), int'(d_tc[i]), m_tc[i]);
            chk($sformatf("u%0d.Ovf", i), int'(d_ovf[i]), m_ovf[i]);
            chk($sformatf("u%0d.Udf", i), int'(d_udf[i]), m_udf[i]);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic set_in(input bit clr_n, input bit en, input bit ud, input bit ld,
                         input int val, input bit cf);
      Clear    = clr_n;
      EN       = en;
      UD       = ud;
      Load     = ld;
      lv       = 4'(val);
      ClrFlags = cf;
   endtask

   initial begin
      int up_exp [4];
      int dn_exp [4];
      up_exp = '{1, 0, 9, 8};
      set_in(0, 1, 1, 1, 7, 1);
      tick();
      for (int i = 0; i < N; i++) begin
         chk($sformatf("reset u%0d.Count", i), int'(d_cnt[i]), 0);
         chk($sformatf("reset u%0d.flags", i), int'({d_tc[i], d_ovf[i], d_udf[i]}), 0);
      end

      // Count up across the wrap.
      set_in(1, 1, 1, 0, 0, 0);
      for (int k = 1; k <= 12; k++) begin
         tick();
         chk("up.Count", int'(d_cnt[0]), k % 10);
         chk("up.TC", int'(d_tc[0]), (k == 10) ? 1 : 0);
         chk("up.Ovf", int'(d_ovf[0]), (k >= 10) ? 1 : 0);
      end

      // Count is 2: down across the wrap.
      set_in(1, 1, 0, 0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         tick();
         chk("down.Count", int'(d_cnt[0]), up_exp[k]);
         chk("down.TC", int'(d_tc[0]), (k == 2) ? 1 : 0);
      end
      chk("down.Udf", int'(d_udf[0]), 1);
      chk("down.Ovf", int'(d_ovf[0]), 1);

      // Saturating instance held at MAX.
      dn_exp = '{9, 9, 9, 0};
      set_in(1, 0, 1, 1, 8, 0);
      tick();
      set_in(1, 1, 1, 0, 0, 0);
      for (int k = 0; k < 3; k++) begin
         tick();
         chk("sat.Count", int'(d_cnt[1]), dn_exp[k]);
         chk("sat.TC", int'(d_tc[1]), (k == 0) ? 0 : 1);
      end
      chk("sat.Ovf", int'(d_ovf[1]), 1);

      // Load clamps to MAX and beats counting.
      set_in(1, 0, 1, 1, 13, 0);
      tick();
      chk("load13.Count", int'(d_cnt[0]), 9);
      set_in(1, 1, 1, 1, 4, 0);
      tick();
      chk("load_vs_en.Count", int'(d_cnt[0]), 4);
      chk("load_vs_en.TC", int'(d_tc[0]), 0);

      // STEP=3 wrap in both directions.
      set_in(1, 0, 1, 1, 8, 0);
      tick();
      set_in(1, 1, 1, 0, 0, 0);
      tick();
      chk("step3.up.Count", int'(d_cnt[2]), 1);
      chk("step3.up.TC", int'(d_tc[2]), 1);
      set_in(1, 1, 0, 0, 0, 0);
      tick();
      chk("step3.dn.Count", int'(d_cnt[2]), 8);
      chk("step3.dn.TC", int'(d_tc[2]), 1);
      chk("step3.dn.Udf", int'(d_udf[2]), 1);

      // Set beats ClrFlags; plain ClrFlags then clears; Clear mid-count.
      set_in(1, 0, 1, 1, 9, 0);
      tick();
      set_in(1, 1, 1, 0, 0, 1);
      tick();
      chk("setwins.Count", int'(d_cnt[0]), 0);
      chk("setwins.Ovf", int'(d_ovf[0]), 1);
      tick();
      chk("clrflags.Ovf", int'(d_ovf[0]), 0);
      set_in(1, 0, 1, 1, 6, 0);
      tick();
      chk("pre_clear.Count", int'(d_cnt[0]), 6);
      set_in(0, 1, 1, 0, 0, 0);
      tick();
      chk("clear.Count", int'(d_cnt[0]), 0);
      chk("clear.flags", int'({d_tc[0], d_ovf[0], d_udf[0]}), 0);

      // Randomised traffic, checked by the model on every cycle.
      for (int k = 0; k < 3000; k++) begin
         set_in($urandom_range(0, 63) != 0, $urandom_range(0, 3) != 0, 1'($urandom),
                $urandom_range(0, 7) == 0, int'($urandom_range(0, 15)),
                $urandom_range(0, 7) == 0);
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
